// File: rtl/alu_md_pkg.sv
// Shared opcode map and FSM encoding for the alu_md block.
// Opcodes 0x16-0x1F are deliberately left undefined and decode as illegal.
package alu_md_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_NOR   = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_EQ    = 5'h06;
  localparam logic [4:0] OP_SLTU  = 5'h07;
  localparam logic [4:0] OP_SLT   = 5'h08;
  localparam logic [4:0] OP_SLL   = 5'h09;
  localparam logic [4:0] OP_SRL   = 5'h0A;
  localparam logic [4:0] OP_ADDU  = 5'h0B;
  localparam logic [4:0] OP_SUBU  = 5'h0C;
  localparam logic [4:0] OP_SRA   = 5'h0D;
  localparam logic [4:0] OP_MULT  = 5'h0E;
  localparam logic [4:0] OP_MULTU = 5'h0F;
  localparam logic [4:0] OP_DIV   = 5'h10;
  localparam logic [4:0] OP_DIVU  = 5'h11;
  localparam logic [4:0] OP_MFHI  = 5'h12;
  localparam logic [4:0] OP_MFLO  = 5'h13;
  localparam logic [4:0] OP_MTHI  = 5'h14;
  localparam logic [4:0] OP_MTLO  = 5'h15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes.
// done_o marks the edge that completes the last iteration; hi_o/lo_o are valid then.
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, div_q, div0_q, neg_q, sign_a_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, a_raw_q;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, opb_q});
  assign rem_next = ge ? (shifted[WIDTH-1:0] - opb_q) : shifted[WIDTH-1:0];

  assign acc_d = div_q ? {rem_next, acc_q[WIDTH-2:0], ge}
                       : {mul_sum, acc_q[WIDTH-1:1]};

  assign prod    = neg_q ? -acc_d : acc_d;
  assign quo_fix = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
  assign rem_fix = sign_a_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign div0_o = div_q && div0_q;
  assign hi_o   = div_q ? (div0_q ? a_raw_q : rem_fix) : prod[2*WIDTH-1:WIDTH];
  assign lo_o   = div_q ? (div0_q ? '1 : quo_fix) : prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      div0_q   <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      div_q    <= div_i;
      div0_q   <= div_i && (b_i == '0);
      neg_q    <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      sign_a_q <= signed_i && a_i[WIDTH-1];
      cnt_q    <= '0;
      acc_q    <= {{WIDTH{1'b0}}, a_mag};
      opb_q    <= b_mag;
      a_raw_q  <= a_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md.sv
// ALU with single-cycle ops and an iterative multiply/divide unit sharing HI/LO.
// Single-cycle results register on the accept edge; mul/div results on the last iteration edge.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHAMT_LSB = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       control_signal,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             flag_q, flag_d, err_q, err_d, out_valid_q, out_valid_d;

  logic             accept, iter_start, iter_done, iter_div0;
  logic [WIDTH-1:0] iter_hi, iter_lo, sum, diff;
  logic [SW-1:0]    shamt;
  logic             ovf_add, ovf_sub;

  assign in_ready   = (state_q == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter_op(control_signal);
  assign shamt      = data_2[SHAMT_LSB +: SW];
  assign sum        = data_1 + data_2;
  assign diff       = data_1 - data_2;
  assign ovf_add    = (data_1[WIDTH-1] == data_2[WIDTH-1]) && (sum[WIDTH-1]  != data_1[WIDTH-1]);
  assign ovf_sub    = (data_1[WIDTH-1] != data_2[WIDTH-1]) && (diff[WIDTH-1] != data_1[WIDTH-1]);

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (iter_start),
    .signed_i ((control_signal == OP_MULT) || (control_signal == OP_DIV)),
    .div_i    ((control_signal == OP_DIV) || (control_signal == OP_DIVU)),
    .a_i      (data_1),
    .b_i      (data_2),
    .done_o   (iter_done),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo),
    .div0_o   (iter_div0)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    flag_d      = 1'b0;
    err_d       = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((control_signal == OP_MULT) || (control_signal == OP_MULTU)) begin
            state_d = ST_MUL;
          end else if ((control_signal == OP_DIV) || (control_signal == OP_DIVU)) begin
            state_d = ST_DIV;
          end else begin
            out_valid_d = 1'b1;
            result_d    = '0;
            case (control_signal)
              OP_ADD:  begin result_d = sum;  flag_d = ovf_add; end
              OP_SUB:  begin result_d = diff; flag_d = ovf_sub; end
              OP_ADDU: result_d = sum;
              OP_SUBU: result_d = diff;
              OP_AND:  result_d = data_1 & data_2;
              OP_OR:   result_d = data_1 | data_2;
              OP_NOR:  result_d = ~(data_1 | data_2);
              OP_XOR:  result_d = data_1 ^ data_2;
              OP_EQ:   flag_d   = (data_1 == data_2);
              OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (data_1 < data_2)};
              OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(data_1) < $signed(data_2))};
              OP_SLL:  result_d = data_1 << shamt;
              OP_SRL:  result_d = data_1 >> shamt;
              OP_SRA:  result_d = $unsigned($signed(data_1) >>> shamt);
              OP_MFHI: result_d = hi_q;
              OP_MFLO: result_d = lo_q;
              OP_MTHI: begin hi_d = data_1; result_d = data_1; end
              OP_MTLO: begin lo_d = data_1; result_d = data_1; end
              default: err_d = 1'b1;
            endcase
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          state_d     = ST_DONE;
          hi_d        = iter_hi;
          lo_d        = iter_lo;
          result_d    = iter_lo;
          err_d       = iter_div0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag      = flag_q;
  assign err       = err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md (WIDTH=32): a behavioural model queues expected
// results at accept, a negedge monitor pops and compares on every out_valid.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  control_signal = '0;
  logic [31:0] data_1 = '0, data_2 = '0;
  logic        out_valid, flag, err;
  logic [31:0] result, hi, lo;

  alu_md #(.WIDTH(32), .SHAMT_LSB(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control_signal(control_signal), .data_1(data_1), .data_2(data_2),
    .out_valid(out_valid), .result(result), .flag(flag), .err(err),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] res;
    logic        flag;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0, n_fail = 0;
  int          cycle_cnt = 0, ov_count = 0, n_expected = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: wide signed arithmetic rather than bit-level logic.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint      sa, sb, s;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[10:6];
    e.op = op; e.res = '0; e.flag = 1'b0; e.err = 1'b0; e.cyc = 0;
    case (op)
      5'h00: begin s = sa + sb; e.res = a + b; e.flag = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'h01: begin s = sa - sb; e.res = a - b; e.flag = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'h02: e.res = a & b;
      5'h03: e.res = a | b;
      5'h04: e.res = ~(a | b);
      5'h05: e.res = a ^ b;
      5'h06: e.flag = (a == b);
      5'h07: e.res = (a < b) ? 32'd1 : 32'd0;
      5'h08: e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'h09: e.res = a << sh;
      5'h0A: e.res = a >> sh;
      5'h0B: e.res = a + b;
      5'h0C: e.res = a - b;
      5'h0D: e.res = $unsigned($signed(a) >>> sh);
      5'h0E: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
      5'h0F: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
      5'h10, 5'h11: begin
        if (b == 32'd0) begin
          lo_m = '1; hi_m = a; e.err = 1'b1;
        end else if (op == 5'h10) begin
          s = sa / sb; lo_m = s[31:0];
          s = sa % sb; hi_m = s[31:0];
        end else begin
          lo_m = a / b; hi_m = a % b;
        end
        e.res = lo_m;
      end
      5'h12: e.res = hi_m;
      5'h13: e.res = lo_m;
      5'h14: begin hi_m = a; e.res = a; end
      5'h15: begin lo_m = a; e.res = a; end
      default: e.err = 1'b1;
    endcase
    e.hi = hi_m;
    e.lo = lo_m;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check_val("ready_timeout", {63'd0, in_ready}, 64'd1);
    control_signal = op; data_1 = a; data_2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(op, a, b, e);
    e.cyc = cycle_cnt - 1 + (((op >= 5'h0E) && (op <= 5'h11)) ? 33 : 1);
    sb_q.push_back(e);
    n_expected++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      ov_count++;
      if (sb_q.size() == 0) begin
        check_val("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("op=%02h result=%08h flag=%0b err=%0b hi=%08h lo=%08h cyc=%0d",
                 e.op, result, flag, err, hi, lo, cycle_cnt);
        check_val("result",  64'(result), 64'(e.res));
        check_val("flag",    64'(flag),   64'(e.flag));
        check_val("err",     64'(err),    64'(e.err));
        check_val("hi",      64'(hi),     64'(e.hi));
        check_val("lo",      64'(lo),     64'(e.lo));
        check_val("latency", 64'(cycle_cnt), 64'(e.cyc));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_result",    64'(result),    64'd0);
    check_val("rst_hilo",      {hi, lo},       64'd0);
    check_val("rst_flag_err",  {62'd0, flag, err}, 64'd0);
    rst = 1'b0;
    check_val("rst_in_ready",  64'(in_ready),  64'd1);

    // Back-to-back single-cycle operations, including overflow and shift corners
    send(5'h00, 32'h7FFFFFFF, 32'h1);
    send(5'h0C, 32'd5, 32'd7);
    send(5'h08, 32'h80000032, 32'h31);
    send(5'h07, 32'h80000032, 32'h31);
    send(5'h0D, 32'h80000000, 32'h88);
    send(5'h01, 32'h80000000, 32'h1);
    send(5'h0B, 32'h7FFFFFFF, 32'h1);
    send(5'h06, 32'hDEADBEEF, 32'hDEADBEEF);
    send(5'h06, 32'hDEADBEEF, 32'hDEADBEEE);
    send(5'h04, 32'h0F0F0000, 32'h000000F0);
    send(5'h09, 32'h00000003, 32'h7C0);
    send(5'h0A, 32'h80000000, 32'h7C0);
    send(5'h14, 32'h1234, 32'h0);
    send(5'h12, 32'h0, 32'h0);
    send(5'h15, 32'hCAFE, 32'h0);
    send(5'h13, 32'h0, 32'h0);
    send(5'h1F, 32'h55, 32'hAA);
    send(5'h16, 32'h55, 32'hAA);

    // Multiply with in_ready held low from accept through DONE
    send(5'h0E, 32'hFFFFFFFD, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      check_val("mul_busy_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    check_val("mul_ready_back", 64'(in_ready), 64'd1);

    send(5'h0F, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(5'h10, 32'hFFFFFFF9, 32'd2);
    send(5'h11, 32'd10, 32'd0);
    send(5'h10, 32'h80000000, 32'hFFFFFFFF);
    send(5'h10, 32'hFFFFFF00, 32'd0);
    send(5'h0E, 32'h80000000, 32'h80000000);
    send(5'h12, 32'h0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      send(5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom());
    end
    drain();

    // Reset ten cycles into a divide aborts it silently
    send(5'h11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    void'(sb_q.pop_back());
    n_expected--;
    hi_m = '0; lo_m = '0;
    check_val("abort_in_ready", 64'(in_ready),  64'd1);
    check_val("abort_hilo",     {hi, lo},       64'd0);
    check_val("abort_result",   64'(result),    64'd0);
    repeat (40) @(posedge clk);
    #1;
    send(5'h00, 32'd1, 32'd2);
    send(5'h12, 32'd0, 32'd0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check_val("out_valid_count", 64'(ov_count), 64'(n_expected));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
